// File: rtl/mips_pkg.sv
// Shared MIPS core constants: architectural register indices, reset value of $sp,
// and default register-file geometry.
package mips_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] SP_INIT_VAL = 32'h7FFF_FFFC;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

endpackage

// File: rtl/regfile_bypass.sv
// One read port's forwarding mux: same-cycle write beats link beats storage,
// and a register being written this cycle is no longer reported as pending.
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_IDX = 31
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_ok,
  input  logic [DATA_W-1:0] link_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              pend_bit,
  output logic [DATA_W-1:0] rd_value,
  output logic              rd_pending
);

  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);

  logic wr_hit;
  logic link_hit;

  // wr_ok already excludes register 0 and out-of-range targets
  assign wr_hit   = wr_ok && (wr_addr == rd_addr);
  assign link_hit = link_ok && (rd_addr == LINK_A);

  always_comb begin
    rd_value = mem_data;
    if (wr_hit)
      rd_value = wr_data;
    else if (link_hit)
      rd_value = link_data;
  end

  assign rd_pending = pend_bit && !wr_hit && !link_hit;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file with write/link bypass, load-pending scoreboard,
// optional registered reads and $v0/$a0 syscall taps.
module regfile_mp
  import mips_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter int                NUM_RD   = 2,
  parameter int                READ_REG = 0,
  parameter int                SP_IDX   = REG_SP,
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_VAL),
  parameter int                LINK_IDX = REG_RA,
  parameter int                V0_IDX   = REG_V0,
  parameter int                A0_IDX   = REG_A0,
  localparam int               ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_data,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic [DATA_W-1:0]        v0,
  output logic [DATA_W-1:0]        a0
);

  // Storage is rounded up to a power of two; slots >= DEPTH are never written
  // and therefore always read 0.
  localparam int MEM_N = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);
  localparam logic [ADDR_W-1:0] V0_A   = ADDR_W'(V0_IDX);
  localparam logic [ADDR_W-1:0] A0_A   = ADDR_W'(A0_IDX);

  logic [DATA_W-1:0] mem [MEM_N];
  logic [MEM_N-1:0]  pending;
  logic [MEM_N-1:0]  valid_map;

  logic wr_ok;
  logic link_ok;
  logic pend_ok;

  for (genvar k = 0; k < MEM_N; k++) begin : g_valid
    assign valid_map[k] = (k < DEPTH);
  end

  assign wr_ok   = wr_en && (wr_addr != '0) && valid_map[wr_addr];
  assign link_ok = link_en && (LINK_IDX != 0);
  assign pend_ok = pend_set && (pend_addr != '0) && valid_map[pend_addr];

  // The wr port is applied after the link port so it wins on a collision at LINK_IDX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MEM_N; k++)
        mem[k] <= (k == SP_IDX) ? SP_INIT : '0;
    end else begin
      if (link_ok)
        mem[LINK_A] <= link_data;
      if (wr_ok)
        mem[wr_addr] <= wr_data;
    end
  end

  // Set is applied last so a newer load outranks a retiring write to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (link_ok)
        pending[LINK_A] <= 1'b0;
      if (wr_ok)
        pending[wr_addr] <= 1'b0;
      if (pend_ok)
        pending[pend_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] byp;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_bypass #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .LINK_IDX(LINK_IDX)
    ) u_bypass (
      .rd_addr   (ra),
      .wr_ok     (wr_ok),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .link_ok   (link_ok),
      .link_data (link_data),
      .mem_data  (mem[ra]),
      .pend_bit  (pending[ra]),
      .rd_value  (byp),
      .rd_pending(rd_pending[i])
    );

    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          rd_q <= '0;
        else
          rd_q <= byp;
      end

      assign rd_data[i*DATA_W +: DATA_W] = rd_q;
    end else begin : g_comb
      assign rd_data[i*DATA_W +: DATA_W] = byp;
    end
  end

  assign v0 = mem[V0_A];
  assign a0 = mem[A0_A];

endmodule
